// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle sequencer that multiplies two unsigned WIDTH-bit operands
// (mod 2^WIDTH) by repeated addition. It drives an external combinational ALU
// and has no adder of its own. The ALU gets an operator code and two operands
// every cycle, and its C_bus result and zero flag come back in the same cycle.
//
// Handshake (start/busy/done):
//   start is a request strobe. It is accepted only on a rising edge where
//   busy=0, which means the FSM is in IDLE. On acceptance a_in/b_in are
//   captured and busy rises in the following cycle. It stays high until the
//   end of the DONE cycle. If start is asserted while busy=1 it is ignored,
//   and that includes the DONE cycle. done is a single-cycle pulse. result is
//   valid from the DONE cycle until the next accepted start.

module alu_mul_sequencer #(
    parameter int         WIDTH   = 16,
    parameter logic [2:0] OP_ADD  = 3'd0,
    parameter logic [2:0] OP_PASS = 3'd2,
    parameter logic [2:0] OP_ZER  = 3'd3,
    parameter logic [2:0] OP_DECA = 3'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_CHK  = 3'd2,
        S_ADD  = 3'd3,
        S_DEC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] acc;

    assign state_dbg = state;

    // ALU drive: operator and operands are a pure function of state and registers
    always_comb begin
        alu_op = OP_ZER;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            S_IDLE: alu_op = OP_ZER;
            S_CLR:  alu_op = OP_ZER;
            S_CHK: begin
                alu_op = OP_PASS;
                alu_b  = cnt;
            end
            S_ADD: begin
                alu_op = OP_ADD;
                alu_a  = acc;
                alu_b  = mcand;
            end
            S_DEC: begin
                alu_op = OP_DECA;
                alu_a  = cnt;
            end
            S_DONE: alu_op = OP_ZER;
            default: alu_op = OP_ZER;
        endcase
    end

    // Control FSM with registered busy/done/result; all data updates come from alu_c
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a_in;
                        cnt   <= b_in;
                        busy  <= 1'b1;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    // acc is cleared through the ALU's zero operator
                    acc   <= alu_c;
                    state <= S_CHK;
                end
                S_CHK: begin
                    // A zero multiplier skips the loop entirely
                    if (alu_z) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc   <= alu_c;
                    state <= S_DEC;
                end
                S_DEC: begin
                    // acc is already final here because ADD wrote it last cycle
                    cnt <= alu_c;
                    if (alu_z) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Protocol invariants of the start/busy/done handshake
    a_done_busy: assert property (@(posedge clk) disable iff (rst) done |-> busy);
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_idle_not_busy: assert property (@(posedge clk) disable iff (rst) (state == S_IDLE) |-> !busy);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
// Directed bench for alu_mul_sequencer. A combinational ALU model answers the
// DUT's requests. Each multiply is timed in cycles relative to the edge that
// accepted start (edge 0). Cycle k is the interval between edge k-1 and edge k,
// and it is sampled on its falling edge.

module tb_alu_mul_sequencer;

    localparam int         W       = 16;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_PASS = 3'd2;
    localparam logic [2:0] OP_ZER  = 3'd3;
    localparam logic [2:0] OP_DECA = 3'd4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_c;
    logic         alu_z;
    logic [2:0]   state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [17:0] op_trace;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU reference model
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_PASS: alu_c = alu_b;
            OP_ZER:  alu_c = '0;
            OP_DECA: alu_c = alu_a - 16'd1;
            default: alu_c = '0;
        endcase
        alu_z = (alu_c == '0);
    end

    alu_mul_sequencer #(
        .WIDTH(W), .OP_ADD(OP_ADD), .OP_PASS(OP_PASS), .OP_ZER(OP_ZER), .OP_DECA(OP_DECA)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_z(alu_z), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply. If poke is set, start is re-asserted with other operands from cycle 2 up to and including DONE.
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input int exp_cyc, input bit poke);
        int done_cyc;
        int busy_cnt;
        int add_cnt;
        done_cyc = -1;
        busy_cnt = 0;
        add_cnt  = 0;
        @(negedge clk);
        op_trace = {15'd0, alu_op};
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        for (int k = 1; k <= exp_cyc + 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            if (busy) busy_cnt++;
            if (alu_op == OP_ADD) add_cnt++;
            if (k <= 5) op_trace = {op_trace[14:0], alu_op};
            if (done) begin
                done_cyc = k;
                check({tag, " result at done"}, 32'(result), 32'(exp_res));
            end
            if (poke && k >= 2) begin
                start = 1'b1;
                a_in  = 16'd9;
                b_in  = 16'd9;
            end
            if (done_cyc >= 0) break;
        end
        check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_cyc));
        check({tag, " add ops"}, 32'(add_cnt), 32'(b));
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " done single"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " result held"}, 32'(result), 32'(exp_res));
        check({tag, " idle state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset op", 32'(alu_op), 32'(OP_ZER));
        rst = 1'b0;
        @(negedge clk);

        run_mul("t1 3x4", 16'd3, 16'd4, 16'd12, 11, 1'b0);
        run_mul("t2 b0", 16'h1234, 16'd0, 16'd0, 3, 1'b0);
        run_mul("t3 wrap", 16'h0100, 16'h0101, 16'h0100, 517, 1'b0);
        run_mul("t4 ignore", 16'd5, 16'd2, 16'd10, 7, 1'b1);
        run_mul("t6 b1", 16'd7, 16'd1, 16'd7, 5, 1'b0);
        check("t6 op sequence", 32'(op_trace),
              32'({OP_ZER, OP_ZER, OP_PASS, OP_ADD, OP_DECA, OP_ZER}));
        run_mul("t7 max", 16'hFFFF, 16'd3, 16'hFFFD, 9, 1'b0);

        // Reset in the middle of an operation (cycle 5) aborts it
        @(negedge clk);
        start = 1'b1;
        a_in  = 16'd7;
        b_in  = 16'd6;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t5 busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5 busy after rst", 32'(busy), 32'd0);
        check("t5 result after rst", 32'(result), 32'd0);
        check("t5 state after rst", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t5 no done", 32'(done_seen), 32'd0);
        run_mul("t5 2x3", 16'd2, 16'd3, 16'd6, 9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
